// File: rtl/mod_counter_pkg.sv
// Shared constants and helpers for the modulo-N counter family.
package mod_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  function automatic int unsigned cnt_width(input int unsigned modulus);
    if (modulus > 32'd2) begin
      return $clog2(modulus);
    end else begin
      return 32'd1;
    end
  endfunction

  // Out-of-range load values clamp to the terminal count.
  function automatic logic [31:0] sat_to_mod(input logic [31:0] value,
                                             input logic [31:0] modulus);
    if (value < modulus) begin
      return value;
    end else begin
      return modulus - 32'd1;
    end
  endfunction

endpackage

// File: rtl/mod_n_counter_count_register.sv
// WIDTH-bit state register with enable and asynchronous active-high clear.
module count_register #(
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= {WIDTH{1'b0}};
    end else if (en_i) begin
      count_q <= d_i;
    end
  end

  assign q_o = count_q;

endmodule

// File: rtl/mod_n_counter.sv
// Up/down modulo-N counter with cascade carry and optional parallel load.
// Parallel load is built only when MOD_N_COUNTER_LOAD_EN is defined.
module mod_n_counter
  import mod_counter_pkg::*;
#(
  parameter int MODULUS = 5,
  parameter int WIDTH   = cnt_width(MODULUS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] out,
  output logic             at_max,
  output logic             at_zero,
  output logic             carry_out
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] count_d;
  logic             count_en_s;
  logic             terminal_s;
  logic [WIDTH-1:0] step_d;

  assign at_max     = (out == MAX_VAL);
  assign at_zero    = (out == {WIDTH{1'b0}});
  assign terminal_s = (up_down == DIR_UP) ? at_max : at_zero;

  // Wrap by explicit compare so a power-of-two modulus behaves like any other.
  always_comb begin
    step_d = out;
    if (up_down == DIR_UP) begin
      step_d = at_max ? {WIDTH{1'b0}} : (out + ONE);
    end else begin
      step_d = at_zero ? MAX_VAL : (out - ONE);
    end
  end

`ifdef MOD_N_COUNTER_LOAD_EN
  logic [WIDTH-1:0] load_sat_s;

  assign load_sat_s = WIDTH'(sat_to_mod(32'(load_value), 32'(MODULUS)));
  assign carry_out  = enable && !load && terminal_s;

  // Next-state select: load over count over hold.
  always_comb begin
    count_d    = out;
    count_en_s = 1'b0;
    if (load) begin
      count_d    = load_sat_s;
      count_en_s = 1'b1;
    end else if (enable) begin
      count_d    = step_d;
      count_en_s = 1'b1;
    end else begin
      count_d    = out;
      count_en_s = 1'b0;
    end
  end
`else
  logic load_unused_s;

  assign load_unused_s = ^{load, load_value};
  assign carry_out     = enable && terminal_s;

  // Next-state select: count over hold.
  always_comb begin
    count_d    = out;
    count_en_s = 1'b0;
    if (enable) begin
      count_d    = step_d;
      count_en_s = 1'b1;
    end else begin
      count_d    = out;
      count_en_s = 1'b0;
    end
  end
`endif

  count_register #(
    .WIDTH(WIDTH)
  ) u_count_register (
    .clock (clock),
    .reset (reset),
    .en_i  (count_en_s),
    .d_i   (count_d),
    .q_o   (out)
  );

endmodule

// File: doc/mod_n_counter.md
MOD_N_COUNTER -- requirements
Module: mod_n_counter

Interface
REQ-001 Parameter MODULUS, default 5, number of count states (0..MODULUS-1); legal range 2..65536.
REQ-002 Parameter WIDTH, default $clog2(MODULUS), width of the count bus; SHALL satisfy 2**WIDTH >= MODULUS.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  count-enable; count advances only while high.
REQ-006 up_down  input  1  direction; 1 = increment, 0 = decrement.
REQ-007 load  input  1  synchronous parallel-load request.
REQ-008 load_value  input  WIDTH  value to load.
REQ-009 out  output  WIDTH  current count, registered.
REQ-010 at_max  output  1  combinational; high when out == MODULUS-1.
REQ-011 at_zero  output  1  combinational; high when out == 0.
REQ-012 carry_out  output  1  combinational terminal-count pulse for cascading; high when enable && !load && ((up_down && at_max) || (!up_down && at_zero)).

Function
REQ-013 Priority per edge: reset > load > enable > hold.
REQ-014 Load: out <= load_value if load_value < MODULUS, else out <= MODULUS-1 (saturate); enable and up_down are ignored that cycle.
REQ-015 Up count: out <= out+1, wrapping MODULUS-1 -> 0 in the same edge, with no intermediate value.
REQ-016 Down count: out <= out-1, wrapping 0 -> MODULUS-1 in the same edge.
REQ-017 enable low and load low: out holds.
REQ-018 Latency: one edge from enable/load sampled high to updated out; at_max, at_zero and carry_out follow out with zero cycle delay.
REQ-019 up_down may change on any cycle; the value sampled at the edge decides the step.
REQ-020 out never holds a value >= MODULUS under any input sequence.
REQ-021 When MODULUS == 2**WIDTH, wrap SHALL occur by explicit compare, not natural overflow, so behaviour is identical for every MODULUS.
REQ-022 Two instances cascade by connecting carry_out of the lower stage to enable of the upper stage; the upper stage steps on exactly the edge where the lower wraps.

Reset
REQ-023 reset high forces out = 0 immediately, without waiting for a clock edge; at_zero = 1, at_max = 0 (MODULUS >= 2), carry_out follows REQ-012.
REQ-024 Asserting reset mid-count or during load discards the pending operation; the first edge after deassertion applies the normal REQ-013 priority starting from 0.

Configuration
REQ-025 Macro MOD_N_COUNTER_LOAD_EN: when defined, the load path of REQ-014 is built.
REQ-026 Macro MOD_N_COUNTER_LOAD_EN not defined: load and load_value remain ports but are ignored, no load logic is synthesised, and carry_out drops its !load term.

Structure
REQ-027 Shared package mod_counter_pkg holds the clog2-based width helper function, the direction constants DIR_UP/DIR_DOWN and the saturate-to-modulus function.
REQ-028 One sub-module count_register: WIDTH-bit register with enable and asynchronous active-high reset to 0; next-state selection stays in mod_n_counter.

Verification (MODULUS=5, WIDTH=3 unless noted)
REQ-029 Reset, then enable=1, up_down=1 for 6 edges -> out 1,2,3,4,0,1; carry_out high only in the cycle where out=4; at_max high only when out=4.
REQ-030 From out=0, enable=1, up_down=0 for 3 edges -> out 4,3,2; carry_out high in the cycle where out=0.
REQ-031 MOD_N_COUNTER_LOAD_EN defined: load=1, load_value=3, enable=1 -> out=3 next edge; load_value=7 -> out=4; load and carry_out never high in the same cycle.
REQ-032 Reset asserted between edges while out=3 -> out=0 before the next rising edge; after release with enable=1 -> out=1.
REQ-033 MODULUS=8, WIDTH=3: 9 up edges from 0 -> out ends at 1; down from 0 -> 7.
REQ-034 Two cascaded MODULUS=5 instances, 25 enabled edges -> both outs return to 0; upper stage steps exactly 5 times.
